// File: rtl/ex_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_if
// Description : Request/response bundle between the EX stage and the
//               iterative multiply/divide unit. The unit uses the slave
//               modport; the pipeline (or a testbench) uses the master.
//               Port summary (from the unit's point of view):
//                 i_start        request, sampled only while idle
//                 i_op[1:0]      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//                 i_a, i_b       operands (rs, rt)
//                 i_mthi/i_mtlo  write i_wdata into HI / LO (idle only)
//                 o_busy         operation in progress
//                 o_done         one-cycle completion pulse
//                 o_hi, o_lo     architectural HI / LO registers
// Revision    : 1.0  initial release
// ============================================================================
interface ex_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             i_start;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_mthi;
  logic             i_mtlo;
  logic [WIDTH-1:0] i_wdata;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_hi;
  logic [WIDTH-1:0] o_lo;

  modport slave (
    input  i_start, i_op, i_a, i_b, i_mthi, i_mtlo, i_wdata,
    output o_busy, o_done, o_hi, o_lo
  );

  modport master (
    output i_start, i_op, i_a, i_b, i_mthi, i_mtlo, i_wdata,
    input  o_busy, o_done, o_hi, o_lo
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv
// Description : Iterative radix-2 multiply / divide unit with HI/LO
//               registers. MULT/MULTU use shift-add, DIV/DIVU use
//               restoring division on operand magnitudes; signs are
//               re-applied in a final fix-up cycle. Latency from the
//               accepting edge to valid HI/LO is WIDTH+1 cycles.
//               Ports:
//                 clk   clock, all state changes on the rising edge
//                 rst   synchronous active-high reset
//                 bus   ex_muldiv_if slave modport (request, MTHI/MTLO,
//                       busy/done handshake, HI/LO outputs)
// Revision    : 1.0  initial release
// ============================================================================
module ex_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  ex_muldiv_if.slave bus
);

  localparam int                 c_CNT_W    = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0]   c_MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]   c_ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [c_CNT_W-1:0]   r_cnt;
  logic [1:0]           r_op;
  // r_p holds {accumulator, multiplier} for multiply and
  // {partial remainder, quotient} for divide; both start as {0, |A|}.
  logic [2*WIDTH-1:0]   r_p;
  logic [WIDTH-1:0]     r_dvsr;     // |B|: multiplicand or divisor
  logic [WIDTH-1:0]     r_a_orig;   // raw A, returned in HI on divide-by-zero
  logic                 r_neg_q;    // negate product / quotient
  logic                 r_neg_r;    // negate remainder
  logic                 r_div0;
  logic                 r_ovf;
  logic                 r_busy;
  logic                 r_done;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  // Operand conditioning at the accepting edge
  logic             w_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_abs;
  logic [WIDTH-1:0] w_b_abs;

  // One iteration step
  logic [WIDTH:0]     w_madd;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_rsh;
  logic [WIDTH:0]     w_diff;
  logic               w_qbit;
  logic [2*WIDTH-1:0] w_div_nxt;

  // Sign fix-up
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_hi_fix;
  logic [WIDTH-1:0]   w_lo_fix;

  logic w_accept;

  assign w_accept = (r_state == S_IDLE) && bus.i_start;

  assign w_signed = ~bus.i_op[0];
  assign w_a_neg  = w_signed & bus.i_a[WIDTH-1];
  assign w_b_neg  = w_signed & bus.i_b[WIDTH-1];
  assign w_a_abs  = w_a_neg ? (~bus.i_a + 1'b1) : bus.i_a;
  assign w_b_abs  = w_b_neg ? (~bus.i_b + 1'b1) : bus.i_b;

  // Shift-add: conditionally add the multiplicand to the upper half, then
  // shift the whole accumulator right, retiring one multiplier bit.
  assign w_madd    = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_dvsr} : '0);
  assign w_mul_nxt = {w_madd, r_p[WIDTH-1:1]};

  // Restoring divide: shift {R,Q} left one bit, try subtracting the divisor
  // from the widened remainder and keep the difference when it is >= 0.
  assign w_rsh     = r_p[2*WIDTH-1:WIDTH-1];
  assign w_diff    = w_rsh - {1'b0, r_dvsr};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_div_nxt = {(w_qbit ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0]),
                      r_p[WIDTH-2:0], w_qbit};

  assign w_prod = r_neg_q ? (~r_p + 1'b1) : r_p;
  assign w_quo  = r_neg_q ? (~r_p[WIDTH-1:0] + 1'b1) : r_p[WIDTH-1:0];
  assign w_rem  = r_neg_r ? (~r_p[2*WIDTH-1:WIDTH] + 1'b1) : r_p[2*WIDTH-1:WIDTH];

  always_comb begin
    w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
    w_lo_fix = w_prod[WIDTH-1:0];
    if (r_op[1]) begin
      if (r_div0) begin
        w_hi_fix = r_a_orig;
        w_lo_fix = c_ALL_ONES;
      end else if (r_ovf) begin
        w_hi_fix = '0;
        w_lo_fix = c_MIN_NEG;
      end else begin
        w_hi_fix = w_rem;
        w_lo_fix = w_quo;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (bus.i_start) w_state_nxt = S_CALC;
      S_CALC:  if (r_cnt == c_CNT_LAST) w_state_nxt = S_FIX;
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath and HI/LO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_p      <= '0;
      r_dvsr   <= '0;
      r_a_orig <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      r_done <= (r_state == S_FIX);

      if (w_accept) begin
        r_op     <= bus.i_op;
        r_p      <= {{WIDTH{1'b0}}, w_a_abs};
        r_dvsr   <= w_b_abs;
        r_a_orig <= bus.i_a;
        r_neg_q  <= w_a_neg ^ w_b_neg;
        r_neg_r  <= w_a_neg;
        r_div0   <= bus.i_op[1] && (bus.i_b == '0);
        r_ovf    <= (bus.i_op == 2'b10) && (bus.i_a == c_MIN_NEG) && (bus.i_b == c_ALL_ONES);
        r_cnt    <= '0;
      end else if (r_state == S_IDLE) begin
        // A Start in the same cycle takes priority and drops these writes.
        if (bus.i_mthi) r_hi <= bus.i_wdata;
        if (bus.i_mtlo) r_lo <= bus.i_wdata;
      end

      if (r_state == S_CALC) begin
        r_p   <= r_op[1] ? w_div_nxt : w_mul_nxt;
        r_cnt <= (r_cnt == c_CNT_LAST) ? '0 : r_cnt + 1'b1;
      end

      if (r_state == S_FIX) begin
        r_hi <= w_hi_fix;
        r_lo <= w_lo_fix;
      end
    end
  end

  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_hi   = r_hi;
  assign bus.o_lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv
// Description : Self-checking bench for ex_muldiv. Directed vector table,
//               randomized operations against an arithmetic reference model,
//               and hand-written handshake / reset / MTHI-MTLO sequences.
//               A second instance at WIDTH=8 covers parameterisation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_ex_muldiv;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_if #(.WIDTH(32)) m32 ();
  ex_muldiv_if #(.WIDTH(8))  m8 ();

  ex_muldiv #(.WIDTH(32)) u_dut32 (.clk(clk), .rst(rst), .bus(m32.slave));
  ex_muldiv #(.WIDTH(8))  u_dut8  (.clk(clk), .rst(rst), .bus(m8.slave));

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic plus the architectural special cases.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b00: p = sa * sb;
      2'b01: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'h0) p = {a, 32'hFFFF_FFFF};
        else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'h0, a};
        else begin
          if (op == 2'b11) begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
          end
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end
      end
    endcase
    hi = p[63:32];
    lo = p[31:0];
  endfunction

  // Called at a negedge: request, then wait for Done. lat counts edges after
  // the accepting edge; stable clears if Busy drops or HI/LO move early.
  task automatic launch_wait(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                             output int lat, output logic stable);
    logic [31:0] h0, l0;
    m32.i_op = op; m32.i_a = a; m32.i_b = b; m32.i_start = 1'b1;
    @(negedge clk);
    h0 = m32.o_hi; l0 = m32.o_lo;
    m32.i_start = 1'b0;
    m32.i_op = 2'($urandom); m32.i_a = $urandom; m32.i_b = $urandom;
    lat = 0;
    stable = 1'b1;
    while (!m32.o_done && lat < 200) begin
      if (!m32.o_busy || m32.o_hi !== h0 || m32.o_lo !== l0) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic op_check(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    logic stable;
    @(negedge clk);
    launch_wait(op, a, b, lat, stable);
    check({tag, " latency"}, lat, 33);
    check({tag, " busy and hold"}, stable, 1);
    check({tag, " hi"}, m32.o_hi, ehi);
    check({tag, " lo"}, m32.o_lo, elo);
    check({tag, " busy at done"}, m32.o_busy, 0);
    @(negedge clk);
    check({tag, " done width"}, m32.o_done, 0);
  endtask

  initial begin
    logic [31:0] ehi, elo, ra, rb, lo_prev, hi_prev;
    logic [1:0]  rop;
    int          lat, dn, n;
    logic        stable;

    vecs.push_back('{"mult 5x3",   2'b00, 32'd5,          32'd3,          32'h0000_0000, 32'h0000_000F});
    vecs.push_back('{"mult -2x3",  2'b00, 32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF, 32'hFFFF_FFFA});
    vecs.push_back('{"multu fe*3", 2'b01, 32'hFFFF_FFFE,  32'd3,          32'h0000_0002, 32'hFFFF_FFFA});
    vecs.push_back('{"div -7/2",   2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD});
    vecs.push_back('{"divu 7/2",   2'b11, 32'd7,          32'd2,          32'h0000_0001, 32'h0000_0003});
    vecs.push_back('{"div 9/0",    2'b10, 32'd9,          32'd0,          32'h0000_0009, 32'hFFFF_FFFF});
    vecs.push_back('{"div ovf",    2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000});
    vecs.push_back('{"divu x/0",   2'b11, 32'hF000_0001,  32'd0,          32'hF000_0001, 32'hFFFF_FFFF});

    m32.i_start = 0; m32.i_op = 0; m32.i_a = 0; m32.i_b = 0;
    m32.i_mthi = 0; m32.i_mtlo = 0; m32.i_wdata = 0;
    m8.i_start = 0; m8.i_op = 0; m8.i_a = 0; m8.i_b = 0;
    m8.i_mthi = 0; m8.i_mtlo = 0; m8.i_wdata = 0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset busy", m32.o_busy, 0);
    check("reset done", m32.o_done, 0);
    check("reset hi", m32.o_hi, 0);
    check("reset lo", m32.o_lo, 0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < vecs.size(); i++)
      op_check(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom; rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = $urandom_range(1, 15);
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3: ra = -($urandom_range(1, 1000));
        default: ;
      endcase
      model(rop, ra, rb, ehi, elo);
      op_check($sformatf("rand%0d op%0d", i, rop), rop, ra, rb, ehi, elo);
    end

    // Second Start while busy is ignored, exactly one Done
    @(negedge clk);
    m32.i_op = 2'b00; m32.i_a = 32'd5; m32.i_b = 32'd3; m32.i_start = 1'b1;
    @(negedge clk);
    m32.i_start = 1'b0;
    dn = 0;
    for (int c = 0; c < 60; c++) begin
      if (c == 10) begin
        m32.i_start = 1'b1; m32.i_op = 2'b11; m32.i_a = 32'd100; m32.i_b = 32'd7;
      end else m32.i_start = 1'b0;
      if (m32.o_done) dn++;
      @(negedge clk);
    end
    check("restart done count", dn, 1);
    check("restart hi", m32.o_hi, 32'h0);
    check("restart lo", m32.o_lo, 32'hF);

    // MTLO while busy is dropped
    m32.i_op = 2'b01; m32.i_a = 32'd2; m32.i_b = 32'd3; m32.i_start = 1'b1;
    @(negedge clk);
    m32.i_start = 1'b0;
    repeat (4) @(negedge clk);
    lo_prev = m32.o_lo;
    m32.i_mtlo = 1'b1; m32.i_wdata = 32'h1234;
    @(negedge clk);
    m32.i_mtlo = 1'b0;
    check("mtlo busy lo held", m32.o_lo, lo_prev);
    n = 0;
    while (!m32.o_done && n < 100) begin @(negedge clk); n++; end
    check("mtlo busy done seen", m32.o_done, 1);
    check("mtlo busy result", m32.o_lo, 32'd6);
    @(negedge clk);

    // MTHI / MTLO in idle
    m32.i_mthi = 1'b1; m32.i_wdata = 32'hABCD;
    @(negedge clk);
    m32.i_mthi = 1'b0;
    check("mthi idle", m32.o_hi, 32'h0000_ABCD);
    check("mthi lo untouched", m32.o_lo, 32'd6);
    m32.i_mthi = 1'b1; m32.i_mtlo = 1'b1; m32.i_wdata = 32'h5555;
    @(negedge clk);
    m32.i_mthi = 1'b0; m32.i_mtlo = 1'b0;
    check("mthi+mtlo hi", m32.o_hi, 32'h5555);
    check("mthi+mtlo lo", m32.o_lo, 32'h5555);

    // Start and MTHI together: Start wins
    m32.i_mthi = 1'b1; m32.i_wdata = 32'h9999;
    launch_wait(2'b01, 32'd4, 32'd4, lat, stable);
    m32.i_mthi = 1'b0;
    check("start+mthi latency", lat, 33);
    check("start+mthi hold", stable, 1);
    check("start+mthi hi", m32.o_hi, 32'h0);
    check("start+mthi lo", m32.o_lo, 32'd16);

    // Back-to-back: Start during the Done cycle
    check("b2b done high", m32.o_done, 1);
    launch_wait(2'b10, 32'hFFFF_FF9C, 32'd7, lat, stable);
    model(2'b10, 32'hFFFF_FF9C, 32'd7, ehi, elo);
    check("b2b latency", lat, 33);
    check("b2b hold", stable, 1);
    check("b2b hi", m32.o_hi, ehi);
    check("b2b lo", m32.o_lo, elo);
    @(negedge clk);

    // Reset in the middle of a DIV
    m32.i_op = 2'b10; m32.i_a = 32'd1000; m32.i_b = 32'd3; m32.i_start = 1'b1;
    @(negedge clk);
    m32.i_start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", m32.o_busy, 0);
    check("midrst done", m32.o_done, 0);
    check("midrst hi", m32.o_hi, 0);
    check("midrst lo", m32.o_lo, 0);
    dn = 0;
    for (int c = 0; c < 40; c++) begin
      if (m32.o_done || m32.o_busy) dn++;
      @(negedge clk);
    end
    check("midrst no activity", dn, 0);

    // WIDTH=8: MULTU FF x FF
    m8.i_op = 2'b01; m8.i_a = 8'hFF; m8.i_b = 8'hFF; m8.i_start = 1'b1;
    @(negedge clk);
    m8.i_start = 1'b0;
    check("w8 busy", m8.o_busy, 1);
    n = 0;
    while (!m8.o_done && n < 50) begin @(negedge clk); n++; end
    check("w8 latency", n, 9);
    check("w8 hi", m8.o_hi, 8'hFE);
    check("w8 lo", m8.o_lo, 8'h01);
    @(negedge clk);
    check("w8 done width", m8.o_done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
